release_queue: RTL

RELEASE_QUEUE -- requirements
Module: release_queue

---
 rtl/release_queue_pkg.sv | 11 +
 rtl/release_queue_if.sv | 25 ++
 rtl/relq_ram.sv | 31 +++
 rtl/release_queue.sv | 72 +++++++
 4 files changed

// File: rtl/release_queue_pkg.sv
// release_queue_pkg: shared sizing constants for the rename freelist and its release queue.
// Holds the physical register sizing (PHY_REG_NUM, PHY_REG_SEL), the default tag width
// and the default queue depth used by release_queue and release_queue_if.
package release_queue_pkg;
  localparam int PHY_REG_NUM = 64;
  localparam int PHY_REG_SEL = 6;
  localparam int RELQ_TAG_SEL = PHY_REG_SEL;
  localparam int FREELIST_NUM = PHY_REG_NUM - 32;
  localparam int RELQ_DEPTH = 16;
  localparam int RELQ_DEPTH_SEL = 4;
endpackage

// File: rtl/release_queue_if.sv
// release_queue_if: commit-side release requests and drained-tag outputs of release_queue.
// master: drives com_valid_1/2, com_tag_1/2, hold; observes released_1..3, released_valid_1..3,
//         commit_stall, overflow.
// slave:  the queue side, directions reversed.
interface release_queue_if
  import release_queue_pkg::*;
#(
  parameter int TAG_SEL = RELQ_TAG_SEL
);
  logic com_valid_1, com_valid_2, hold;
  logic [TAG_SEL-1:0] com_tag_1, com_tag_2;
  logic [TAG_SEL-1:0] released_1, released_2, released_3;
  logic released_valid_1, released_valid_2, released_valid_3;
  logic commit_stall, overflow;
  modport master (
    output com_valid_1, com_valid_2, com_tag_1, com_tag_2, hold,
    input released_1, released_2, released_3,
    input released_valid_1, released_valid_2, released_valid_3, commit_stall, overflow
  );
  modport slave (
    input com_valid_1, com_valid_2, com_tag_1, com_tag_2, hold,
    output released_1, released_2, released_3,
    output released_valid_1, released_valid_2, released_valid_3, commit_stall, overflow
  );
endinterface

// File: rtl/relq_ram.sv
// relq_ram: DEPTH x TAG_SEL tag storage, 2 write ports, 3 asynchronous read ports, no reset.
// Ports: clk; we_1/wa_1/wd_1 and we_2/wa_2/wd_2 write; ra_1..3 -> rd_1..3 combinational read.
// The two write addresses are never equal when both enables are high.
module relq_ram #(
  parameter int DEPTH = 16,
  parameter int DEPTH_SEL = 4,
  parameter int TAG_SEL = 6
) (
  input  logic                 clk,
  input  logic                 we_1,
  input  logic                 we_2,
  input  logic [DEPTH_SEL-1:0] wa_1,
  input  logic [DEPTH_SEL-1:0] wa_2,
  input  logic [TAG_SEL-1:0]   wd_1,
  input  logic [TAG_SEL-1:0]   wd_2,
  input  logic [DEPTH_SEL-1:0] ra_1,
  input  logic [DEPTH_SEL-1:0] ra_2,
  input  logic [DEPTH_SEL-1:0] ra_3,
  output logic [TAG_SEL-1:0]   rd_1,
  output logic [TAG_SEL-1:0]   rd_2,
  output logic [TAG_SEL-1:0]   rd_3
);
  logic [TAG_SEL-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_1) mem[wa_1] <= wd_1;
    if (we_2) mem[wa_2] <= wd_2;
  end
  assign rd_1 = mem[ra_1];
  assign rd_2 = mem[ra_2];
  assign rd_3 = mem[ra_3];
endmodule

// File: rtl/release_queue.sv
// release_queue: circular FIFO of stale tags freed at commit, drained up to 3 per cycle
// into the freelist unless hold is high.
// Ports: clk; reset (async, active low); bus (release_queue_if.slave) carrying the two
// commit pushes, hold, three released tag/valid slots, commit_stall and sticky overflow.
// Optional RELQ_BYPASS_EN: on an empty queue with hold low, pushes go straight to
// released_1/2 in the same cycle and are not stored.
module release_queue
  import release_queue_pkg::*;
#(
  parameter int TAG_SEL = RELQ_TAG_SEL,
  parameter int DEPTH = RELQ_DEPTH,
  parameter int DEPTH_SEL = RELQ_DEPTH_SEL
) (
  input logic clk,
  input logic reset,
  release_queue_if.slave bus
);
  logic [DEPTH_SEL-1:0] head, tail;
  logic [DEPTH_SEL:0] cnt, free;
  logic [1:0] n, req, acc;
  logic byp;
  logic [TAG_SEL-1:0] first_tag, rd_1, rd_2, rd_3;
  // Everything below derives from registered count, never from this cycle's pushes.
  assign n = bus.hold ? 2'd0 : (cnt > (DEPTH_SEL+1)'(3) ? 2'd3 : cnt[1:0]);
  assign free = (DEPTH_SEL+1)'(DEPTH) - cnt + (DEPTH_SEL+1)'(n);
  assign req = {1'b0, bus.com_valid_1} + {1'b0, bus.com_valid_2};
`ifdef RELQ_BYPASS_EN
  assign byp = reset && cnt == '0 && !bus.hold;
`else
  assign byp = 1'b0;
`endif
  // With a single free slot the earlier-ordered request wins, so com_2 is the one dropped.
  assign acc = byp ? 2'd0 : free == '0 ? 2'd0 :
               (free == (DEPTH_SEL+1)'(1) && req == 2'd2) ? 2'd1 : req;
  // A lone com_valid_2 occupies the first tail slot.
  assign first_tag = bus.com_valid_1 ? bus.com_tag_1 : bus.com_tag_2;
  relq_ram #(.DEPTH(DEPTH), .DEPTH_SEL(DEPTH_SEL), .TAG_SEL(TAG_SEL)) ram (
    .clk(clk),
    .we_1(acc != 2'd0),
    .we_2(acc == 2'd2),
    .wa_1(tail),
    .wa_2(tail + DEPTH_SEL'(1)),
    .wd_1(first_tag),
    .wd_2(bus.com_tag_2),
    .ra_1(head),
    .ra_2(head + DEPTH_SEL'(1)),
    .ra_3(head + DEPTH_SEL'(2)),
    .rd_1(rd_1),
    .rd_2(rd_2),
    .rd_3(rd_3)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      bus.overflow <= 1'b0;
    end else begin
      head <= head + DEPTH_SEL'(n);
      tail <= tail + DEPTH_SEL'(acc);
      cnt <= cnt + (DEPTH_SEL+1)'(acc) - (DEPTH_SEL+1)'(n);
      bus.overflow <= bus.overflow || (!byp && acc != req);
    end
  end
  assign bus.released_1 = byp ? first_tag : rd_1;
  assign bus.released_2 = byp ? bus.com_tag_2 : rd_2;
  assign bus.released_3 = rd_3;
  assign bus.released_valid_1 = byp ? (bus.com_valid_1 || bus.com_valid_2) : n != 2'd0;
  assign bus.released_valid_2 = byp ? (bus.com_valid_1 && bus.com_valid_2) : n[1];
  assign bus.released_valid_3 = !byp && n == 2'd3;
  assign bus.commit_stall = cnt >= (DEPTH_SEL+1)'(DEPTH - 1);
endmodule
